// File: rtl/ddr_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the DDR read-channel arbiter: arbiter FSM state
// encoding and the default address/length/data widths used by the fetch
// controllers.
// ---------------------------------------------------------------------------
package ddr_arb_pkg;

    localparam int DDR_ADDR_LEN = 32;   // DDR byte-address width
    localparam int SINGLE_LEN   = 24;   // transfer length, in 512-bit beats
    localparam int DDR_DATA_LEN = 512;  // read-data width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Width of a requester index; never zero so a single requester still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at requester ptr_i and
// wraps; the first pending requester found wins.
//
// Ports:
//   pending_i  in   N_REQ   requesters with a queued transfer
//   ptr_i      in   PTR_W   index searched first
//   win_o      out  N_REQ   one-hot winner (0 when nothing pending)
//   valid_o    out  1       a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] dbl_rot;
    logic [2*N_REQ-1:0] dbl_win;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_win;

    // Rotate the request vector so ptr_i lands at bit 0, take the lowest set
    // bit, then rotate the one-hot result back into requester order.
    assign dbl     = {pending_i, pending_i};
    assign dbl_rot = dbl >> ptr_i;
    assign rot     = dbl_rot[N_REQ-1:0];
    assign rot_win = rot & (~rot + {{(N_REQ-1){1'b0}}, 1'b1});
    assign dbl_win = {{N_REQ{1'b0}}, rot_win} << ptr_i;
    assign win_o   = dbl_win[N_REQ-1:0] | dbl_win[2*N_REQ-1:N_REQ];
    assign valid_o = |pending_i;

endmodule

// File: rtl/ddr_read_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_read_arbiter
// Shares the single DDR read channel (MIG UI adapter command + read FIFO)
// among N_REQ fetch controllers (0 = bias, 1 = weights, 2 = data). Each
// requester posts one transfer with a one-cycle req_conf pulse; transfers are
// granted round-robin and the read FIFO is routed to the owner until exactly
// the requested number of beats has been popped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_st_addr/req_len per-requester start address / beat count (flat slices)
//   req_conf            per-requester one-cycle request pulse
//   req_fifo_empty      per-requester FIFO empty view (1 unless owner streaming)
//   req_fifo_req        per-requester FIFO pop
//   req_fifo_data       read data, broadcast
//   ddr_st_addr_out     granted start address (held ISSUE..DONE)
//   ddr_len             granted beat count (held ISSUE..DONE)
//   ddr_conf            one-cycle command pulse to the DDR adapter
//   ddr_fifo_empty/req/data  DDR read FIFO
//   grant               one-hot owner, 0 when idle
//   busy                transfer in flight or any request pending
//   req_overrun         sticky: request arrived while one was already pending
// ---------------------------------------------------------------------------
module ddr_read_arbiter #(
    parameter int N_REQ        = 3,
    parameter int DDR_ADDR_LEN = ddr_arb_pkg::DDR_ADDR_LEN,
    parameter int SINGLE_LEN   = ddr_arb_pkg::SINGLE_LEN,
    parameter int DDR_DATA_LEN = ddr_arb_pkg::DDR_DATA_LEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ*DDR_ADDR_LEN-1:0] req_st_addr,
    input  logic [N_REQ*SINGLE_LEN-1:0]   req_len,
    input  logic [N_REQ-1:0]              req_conf,
    output logic [N_REQ-1:0]              req_fifo_empty,
    input  logic [N_REQ-1:0]              req_fifo_req,
    output logic [DDR_DATA_LEN-1:0]       req_fifo_data,
    output logic [DDR_ADDR_LEN-1:0]       ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]         ddr_len,
    output logic                          ddr_conf,
    input  logic                          ddr_fifo_empty,
    output logic                          ddr_fifo_req,
    input  logic [DDR_DATA_LEN-1:0]       ddr_fifo_data,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic [N_REQ-1:0]              req_overrun
);

    import ddr_arb_pkg::*;

    localparam int PTR_W = idx_width(N_REQ);

    // Per-requester request slots
    logic [N_REQ-1:0]                   pending_q;
    logic [N_REQ-1:0]                   overrun_q;
    logic [N_REQ-1:0][DDR_ADDR_LEN-1:0] addr_q;
    logic [N_REQ-1:0][SINGLE_LEN-1:0]   len_q;
    logic [N_REQ-1:0]                   clr_pend;

    // Channel ownership
    arb_state_e             state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [DDR_ADDR_LEN-1:0] st_addr_q, st_addr_d;
    logic [SINGLE_LEN-1:0]  len_out_q, len_out_d;
    logic [SINGLE_LEN-1:0]  remaining_q, remaining_d;

    logic [N_REQ-1:0]       arb_win;
    logic                   arb_valid;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   pop;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .win_o     (arb_win),
        .valid_o   (arb_valid)
    );

    // One-hot to index for the arbiter winner and the current owner.
    always_comb begin
        win_idx = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_win[i]) win_idx = PTR_W'(i);
            if (grant_q[i]) gnt_idx = PTR_W'(i);
        end
    end

    // Slot update. The owner's slot is released in DONE; a new pulse from the
    // owner in that same cycle lands in the freed slot rather than overrunning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_conf[i] && pending_q[i] && !clr_pend[i]) begin
                    overrun_q[i] <= 1'b1;
                end else if (req_conf[i]) begin
                    pending_q[i] <= 1'b1;
                    addr_q[i]    <= req_st_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                    len_q[i]     <= req_len[i*SINGLE_LEN +: SINGLE_LEN];
                end else if (clr_pend[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            st_addr_q   <= '0;
            len_out_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            st_addr_q   <= st_addr_d;
            len_out_q   <= len_out_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        st_addr_d      = st_addr_q;
        len_out_d      = len_out_q;
        remaining_d    = remaining_q;
        clr_pend       = '0;
        pop            = 1'b0;
        req_fifo_empty = '1;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_win;
                    st_addr_d   = addr_q[win_idx];
                    len_out_d   = len_q[win_idx];
                    remaining_d = len_q[win_idx];
                    // Zero-length transfers never touch the DDR channel.
                    state_d     = (len_q[win_idx] == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_d = STREAM;
            end
            STREAM: begin
                // Hide the FIFO from the owner once its beat count is used up,
                // so it cannot eat data belonging to the next transfer.
                req_fifo_empty[gnt_idx] = ddr_fifo_empty || (remaining_q == '0);
                pop = req_fifo_req[gnt_idx] && !ddr_fifo_empty && (remaining_q != '0);
                if (pop) begin
                    remaining_d = remaining_q - SINGLE_LEN'(1);
                    if (remaining_q == SINGLE_LEN'(1)) state_d = DONE;
                end
            end
            DONE: begin
                clr_pend = grant_q;
                ptr_d    = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ddr_fifo_req    = pop;
    assign ddr_conf        = (state_q == ISSUE);
    assign ddr_st_addr_out = st_addr_q;
    assign ddr_len         = len_out_q;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE) || (|pending_q);
    assign req_overrun     = overrun_q;
    assign req_fifo_data   = ddr_fifo_data;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_read_arbiter
// Directed scenarios followed by random traffic. A transaction-level model
// (slots, owner, beats left, phase) predicts every output each cycle; the
// directed scenarios add hand-computed expectations on top.
// ---------------------------------------------------------------------------
module tb_ddr_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 24;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] req_st_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_conf;
    logic [N-1:0]    req_fifo_empty;
    logic [N-1:0]    req_fifo_req;
    logic [DW-1:0]   req_fifo_data;
    logic [AW-1:0]   ddr_st_addr_out;
    logic [LW-1:0]   ddr_len;
    logic            ddr_conf;
    logic            ddr_fifo_empty;
    logic            ddr_fifo_req;
    logic [DW-1:0]   ddr_fifo_data;
    logic [N-1:0]    grant;
    logic            busy;
    logic [N-1:0]    req_overrun;

    always #5 clk = ~clk;

    ddr_read_arbiter #(.N_REQ(N), .DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DDR_DATA_LEN(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_st_addr(req_st_addr), .req_len(req_len), .req_conf(req_conf),
        .req_fifo_empty(req_fifo_empty), .req_fifo_req(req_fifo_req), .req_fifo_data(req_fifo_data),
        .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
        .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req), .ddr_fifo_data(ddr_fifo_data),
        .grant(grant), .busy(busy), .req_overrun(req_overrun)
    );

    int nerr = 0;
    int nchk = 0;
    bit chk_en = 0;

    // Behavioural model: phase 0 waiting, 1 command, 2 streaming, 3 release
    int          m_phase, m_owner, m_rem, m_ptr;
    bit          m_pend [N];
    bit          m_ovr  [N];
    logic [AW-1:0] m_addr [N];
    logic [LW-1:0] m_len  [N];
    logic [AW-1:0] m_oaddr;
    logic [LW-1:0] m_olen;

    // Record of every command seen on the DDR side
    int            cq_g[$];
    logic [AW-1:0] cq_a[$];
    logic [LW-1:0] cq_l[$];
    int            pops_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = -1; m_rem = 0; m_ptr = 0;
        m_oaddr = '0; m_olen = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ovr[i] = 0; m_addr[i] = '0; m_len[i] = '0;
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] e_grant, e_empty, e_ovr;
        logic e_pop, e_busy;
        int w, gi;
        e_grant = '0; e_empty = '1; e_ovr = '0; e_pop = 1'b0; e_busy = 1'b0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        if (m_phase == 2) begin
            e_empty[m_owner] = ddr_fifo_empty || (m_rem == 0);
            e_pop = req_fifo_req[m_owner] && !ddr_fifo_empty && (m_rem != 0);
        end
        e_busy = (m_phase != 0);
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) e_busy = 1'b1;
            e_ovr[i] = m_ovr[i];
        end
        if (chk_en) begin
            chk("grant", grant, e_grant);
            chk("ddr_conf", ddr_conf, m_phase == 1);
            chk("ddr_st_addr_out", ddr_st_addr_out, m_oaddr);
            chk("ddr_len", ddr_len, m_olen);
            chk("req_fifo_empty", req_fifo_empty, e_empty);
            chk("ddr_fifo_req", ddr_fifo_req, e_pop);
            chk("busy", busy, e_busy);
            chk("req_overrun", req_overrun, e_ovr);
            nchk++;
            if (req_fifo_data !== ddr_fifo_data) begin
                nerr++;
                $display("FAIL req_fifo_data: actual=%0h required=%0h", req_fifo_data[63:0], ddr_fifo_data[63:0]);
            end
            if (ddr_conf === 1'b1) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                cq_g.push_back(gi); cq_a.push_back(ddr_st_addr_out); cq_l.push_back(ddr_len);
            end
            if (ddr_fifo_req === 1'b1) pops_total++;
        end
        // Advance to the state seen after the coming rising edge
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    w = -1;
                    for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    if (w >= 0) begin
                        m_owner = w; m_oaddr = m_addr[w]; m_olen = m_len[w]; m_rem = int'(m_len[w]);
                        m_phase = (m_len[w] == 0) ? 3 : 1;
                    end
                end
                1: m_phase = 2;
                2: if (e_pop) begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 3;
                end
                default: begin
                    m_pend[m_owner] = 0;
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_phase = 0;
                end
            endcase
            for (int i = 0; i < N; i++) begin
                if (req_conf[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1;
                    else begin
                        m_pend[i] = 1;
                        m_addr[i] = req_st_addr[i*AW +: AW];
                        m_len[i]  = req_len[i*LW +: LW];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        for (int j = 0; j < DW / 32; j++) ddr_fifo_data[j*32 +: 32] = $urandom;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_st_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]     = l;
        req_conf[i]             = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < max);
        chk({nm, " reaches idle"}, busy, 1'b0);
        tick();
    endtask

    task automatic wait_stream(input string nm, input logic [N-1:0] g);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!(grant == g && !ddr_conf) && k < 40);
        chk({nm, " reaches stream"}, grant, g);
    endtask

    task automatic main_seq();
        int bc, bp, n, k;
        repeat (2) @(posedge clk);
        #1; chk_en = 1; rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst grant", grant, 3'b000);
        chk("rst busy", busy, 1'b0);
        chk("rst req_fifo_empty", req_fifo_empty, 3'b111);
        chk("rst ddr_fifo_req", ddr_fifo_req, 1'b0);
        chk("rst ddr_conf", ddr_conf, 1'b0);
        chk("rst addr", ddr_st_addr_out, 0);
        chk("rst len", ddr_len, 0);
        chk("rst overrun", req_overrun, 3'b000);
        tick();

        // Single request
        ddr_fifo_empty = 1'b0; req_fifo_req = 3'b010;
        bc = cq_g.size(); bp = pops_total;
        set_req(1, 32'h1000, 24'd4); tick(); req_conf = '0;
        wait_idle("single", 40);
        chk("single conf count", cq_g.size() - bc, 1);
        chk("single beats", pops_total - bp, 4);
        if (cq_g.size() > bc) begin
            chk("single owner", cq_g[bc], 1);
            chk("single addr", cq_a[bc], 32'h1000);
            chk("single len", cq_l[bc], 4);
        end
        chk("single grant after", grant, 3'b000);

        // Round-robin from a fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_fifo_req = 3'b111;
        bc = cq_g.size(); bp = pops_total;
        set_req(0, 32'h2000, 24'd2); set_req(1, 32'h3000, 24'd2); set_req(2, 32'h4000, 24'd2);
        tick(); req_conf = '0;
        wait_stream("rr", 3'b010);
        tick(); set_req(0, 32'h5000, 24'd2); tick(); req_conf = '0;
        wait_idle("rr", 60);
        chk("rr conf count", cq_g.size() - bc, 4);
        chk("rr beats", pops_total - bp, 8);
        if (cq_g.size() >= bc + 4) begin
            chk("rr order 1st", cq_g[bc], 0);
            chk("rr order 2nd", cq_g[bc+1], 1);
            chk("rr order 3rd", cq_g[bc+2], 2);
            chk("rr order 4th", cq_g[bc+3], 0);
            chk("rr 4th addr", cq_a[bc+3], 32'h5000);
        end

        // Isolation: only a non-owner pops
        req_fifo_req = 3'b001; ddr_fifo_empty = 1'b0; bp = pops_total;
        set_req(1, 32'h6000, 24'd5); tick(); req_conf = '0;
        wait_stream("iso", 3'b010);
        repeat (4) begin
            chk("iso ddr_fifo_req", ddr_fifo_req, 1'b0);
            chk("iso empty[0]", req_fifo_empty[0], 1'b1);
            chk("iso empty[1]", req_fifo_empty[1], 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1; req_fifo_req = 3'b010;
        wait_idle("iso", 40);
        chk("iso beats", pops_total - bp, 5);

        // FIFO starvation with toggling empty
        req_fifo_req = 3'b001; ddr_fifo_empty = 1'b1;
        set_req(0, 32'h7000, 24'd3); tick(); req_conf = '0;
        n = 0; k = 0;
        while (n < 3 && k < 60) begin
            @(negedge clk); k++;
            if (ddr_fifo_req) begin
                n++;
                chk("starve pop with data", ddr_fifo_empty, 1'b0);
            end
            if (n < 3) begin @(posedge clk); #1; ddr_fifo_empty = ~ddr_fifo_empty; end
        end
        chk("starve beats", n, 3);
        @(posedge clk); #1; ddr_fifo_empty = 1'b0;
        @(negedge clk);
        chk("starve empty after last", req_fifo_empty[0], 1'b1);
        chk("starve no extra pop", ddr_fifo_req, 1'b0);
        tick();
        wait_idle("starve", 20);

        // Zero length
        bc = cq_g.size();
        set_req(0, 32'h8000, 24'd0); tick(); req_conf = '0;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 10);
        chk("len0 cycles to idle", k, 3);
        tick();
        chk("len0 no conf", cq_g.size() - bc, 0);

        // Overrun keeps the first request
        req_fifo_req = 3'b000; ddr_fifo_empty = 1'b0; bc = cq_g.size();
        set_req(0, 32'h9000, 24'd6); tick(); req_conf = '0;
        set_req(2, 32'hA000, 24'd2); tick(); req_conf = '0;
        set_req(2, 32'hB000, 24'd3); tick(); req_conf = '0;
        @(negedge clk);
        chk("overrun flag", req_overrun, 3'b100);
        @(posedge clk); #1; req_fifo_req = 3'b111;
        wait_idle("overrun", 60);
        chk("overrun conf count", cq_g.size() - bc, 2);
        if (cq_g.size() >= bc + 2) begin
            chk("overrun owner", cq_g[bc+1], 2);
            chk("overrun kept addr", cq_a[bc+1], 32'hA000);
            chk("overrun kept len", cq_l[bc+1], 2);
        end

        // New request from the owner during DONE
        req_fifo_req = 3'b010; ddr_fifo_empty = 1'b0; bc = cq_g.size();
        set_req(1, 32'hC000, 24'd2); tick(); req_conf = '0;
        wait_stream("done", 3'b010);
        tick(); tick();
        set_req(1, 32'hD000, 24'd1);
        @(negedge clk);
        chk("done grant held", grant, 3'b010);
        chk("done no conf", ddr_conf, 1'b0);
        chk("done empty", req_fifo_empty, 3'b111);
        @(posedge clk); #1; req_conf = '0;
        wait_idle("done", 40);
        chk("done overrun", req_overrun, 3'b100);
        chk("done conf count", cq_g.size() - bc, 2);
        if (cq_g.size() >= bc + 2) chk("done new addr", cq_a[bc+1], 32'hD000);

        // Reset in the middle of a stream
        req_fifo_req = 3'b001;
        set_req(0, 32'hE000, 24'd5); tick(); req_conf = '0;
        n = 0; k = 0;
        while (n < 2 && k < 40) begin @(negedge clk); k++; if (ddr_fifo_req) n++; end
        chk("midrst beats before", n, 2);
        @(posedge clk); #1; rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst grant", grant, 3'b000);
        chk("midrst ddr_fifo_req", ddr_fifo_req, 1'b0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst empty", req_fifo_empty, 3'b111);
        chk("midrst overrun", req_overrun, 3'b000);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_conf[i] = ($urandom % 8 == 0);
                req_st_addr[i*AW +: AW] = $urandom;
                req_len[i*LW +: LW] = LW'($urandom_range(0, 5));
            end
            ddr_fifo_empty = ($urandom % 4 == 0);
            req_fifo_req = N'($urandom);
            rst_n = ($urandom % 700 != 0);
            tick();
        end
        rst_n = 1'b1; req_conf = '0; ddr_fifo_empty = 1'b0; req_fifo_req = '1;
        wait_idle("drain", 200);
    endtask

    initial begin
        rst_n = 1'b0; req_conf = '0; req_st_addr = '0; req_len = '0;
        req_fifo_req = '0; ddr_fifo_empty = 1'b1; ddr_fifo_data = '0;
        fork
            forever begin @(negedge clk); model_cycle(); end
            main_seq();
        join_any
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ddr_read_arbiter.md
# ddr_read_arbiter

Arbitrates the single DDR read channel (the MIG user-interface adapter's command/FIFO port) among N_REQ fetch controllers (bias fetch, weight fetch, feature-data fetch). Each requester issues a one-cycle configuration pulse with start address and length. The arbiter queues it, grants the channel round-robin, and forwards the read-data FIFO to the granted requester only. The grant is held until exactly the requested number of beats has been consumed. It replaces the static switch-driven DDR mux; the top-level controller no longer selects the DDR owner.

## Interface
- N_REQ, 3, number of requesters (index 0 = bias, 1 = weights, 2 = data)
- DDR_ADDR_LEN, 32, DDR byte-address width
- SINGLE_LEN, 24, transfer length width, counted in 512-bit beats
- DDR_DATA_LEN, 512, read-data width

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- req_st_addr  in  N_REQ*DDR_ADDR_LEN  per-requester start address, slice i at [i*DDR_ADDR_LEN +: DDR_ADDR_LEN]
- req_len  in  N_REQ*SINGLE_LEN  per-requester beat count
- req_conf  in  N_REQ  one-cycle request pulse; addr/len are valid in the same cycle
- req_fifo_empty  out  N_REQ  per-requester view of FIFO empty
- req_fifo_req  in  N_REQ  per-requester FIFO pop
- req_fifo_data  out  DDR_DATA_LEN  read data, broadcast to all requesters
- ddr_st_addr_out  out  DDR_ADDR_LEN  granted start address
- ddr_len  out  SINGLE_LEN  granted beat count
- ddr_conf  out  1  one-cycle command pulse to the DDR adapter
- ddr_fifo_empty  in  1  DDR read FIFO empty
- ddr_fifo_req  out  1  DDR read FIFO pop
- ddr_fifo_data  in  DDR_DATA_LEN  DDR read FIFO data
- grant  out  N_REQ  one-hot current owner; 0 when idle
- busy  out  1  state != IDLE, or any request pending
- req_overrun  out  N_REQ  sticky; set when req_conf[i] arrives while pending[i] is already set

## Operation
- Per-requester slot: pending[i], addr_q[i], len_q[i].
  - req_conf[i] with pending[i]=0: capture addr/len and set pending[i].
  - req_conf[i] with pending[i]=1: the pulse is dropped and req_overrun[i] is set.
- FSM states: IDLE, ISSUE, STREAM, DONE.
- IDLE: if any pending, select a winner by round-robin starting at ptr. Register grant, ddr_st_addr_out, ddr_len, and remaining = len_q. Then go to ISSUE, or go to DONE directly if len_q == 0 (no ddr_conf is issued in that case).
- ISSUE: ddr_conf = 1 for exactly this cycle, then STREAM.
- STREAM, all combinational:
  - req_fifo_empty[g] = ddr_fifo_empty || (remaining == 0)
  - all other req_fifo_empty bits = 1
  - ddr_fifo_req = req_fifo_req[g] && !ddr_fifo_empty && remaining != 0
- Beat counting: each cycle with ddr_fifo_req=1 decrements remaining. The cycle it reaches 0 → DONE. Pops from non-granted requesters are ignored.
- DONE: clear pending[g], set ptr = g+1 mod N_REQ, clear grant, go to IDLE.
- A req_conf[g] arriving in DONE in the same cycle that pending[g] clears is accepted as a new request, not an overrun.
- req_fifo_data = ddr_fifo_data, combinational pass-through.
- Reset values: state IDLE, pending 0, req_overrun 0, ptr 0, grant 0, ddr_conf 0, ddr_st_addr_out 0, ddr_len 0, remaining 0. Consequently ddr_fifo_req = 0, all req_fifo_empty = 1, busy = 0.
- Reset mid-transfer: all pending requests are discarded. Beats left in the DDR FIFO are the DDR adapter's responsibility.

## Timing
- req_conf at cycle t → pending at t+1 → grant and addr/len registered at t+2 (state ISSUE) → ddr_conf high in cycle t+2 → STREAM from t+3.
- ddr_st_addr_out and ddr_len stay stable from ISSUE through DONE.
- Fixed overhead per transaction: 2 cycles (IDLE decision and ISSUE) plus 1 cycle (DONE). Back-to-back grants are therefore separated by 3 non-stream cycles.
- Data path latency is 0 cycles; data is valid in the same cycle as the pop.
- Throughput: one beat per cycle while the DDR FIFO is non-empty.

## Structure
- Package ddr_arb_pkg holds:
  - the FSM state enum (IDLE/ISSUE/STREAM/DONE)
  - default width constants: DDR_ADDR_LEN, SINGLE_LEN, DDR_DATA_LEN
- Sub-module rr_arbiter (combinational): inputs pending[N_REQ] and ptr; outputs a one-hot winner and a valid flag.

## Test plan
- Single request: req_conf[1] with addr 0x1000 and len 4; FIFO always non-empty; requester pops continuously → ddr_conf pulses once with 0x1000/4. Exactly 4 ddr_fifo_req cycles occur, grant returns to 0, busy drops.
- Round-robin: req_conf[0..2] asserted in the same cycle, each with len 2 → grant order 0, 1, 2. A fourth request on 0 raised during STREAM of requester 1 is granted after 2.
- Isolation: during requester 1's stream, requester 0 pops with the FIFO non-empty → ddr_fifo_req stays 0 and req_fifo_empty[0] stays 1.
- FIFO starvation: len 3 with ddr_fifo_empty toggling → ddr_fifo_req asserts only on non-empty cycles. After the 3rd beat, req_fifo_empty[g] = 1 even with data still in the FIFO.
- Edge cases:
  - len 0 → no ddr_conf, pending cleared within 2 cycles.
  - req_conf[2] while pending[2]=1 → req_overrun[2] = 1 and the original addr/len are kept.
  - req_conf[g] in the DONE cycle → accepted as a new request, no overrun.
- Reset mid-STREAM: rst_n low for 1 cycle after 2 of 5 beats → next cycle shows grant 0, ddr_fifo_req 0, busy 0, all req_fifo_empty = 1.
